// File: rtl/monkey_motion_ctrl_if.sv
// Signal bundle between the collision/keyboard side and the monkey motion
// controller. Build option: MONKEY_LIVES_EN adds the lives/gameOver outputs.
//
// Handshake: startOfFrame and hitPulse bits are single-cycle strobes sampled
// on the rising clock edge. There is no back-pressure: every strobe is
// consumed by the controller, so no valid/ready pair exists on this bus.
// Keys are plain levels. All controller outputs are register-driven.
interface monkey_motion_ctrl_if;
    logic               startOfFrame;
    logic [2:0]         hitPulse;
    logic               keyLeft;
    logic               keyRight;
    logic               keyUp;
    logic               keyDown;
    logic               keyJump;
    logic signed [10:0] topLeftX;
    logic signed [10:0] topLeftY;
    logic [1:0]         motionState;
    logic [7:0]         score;
    logic               fruitPulse;
`ifdef MONKEY_LIVES_EN
    logic [1:0]         lives;
    logic               gameOver;

    modport master (
        output startOfFrame, hitPulse, keyLeft, keyRight, keyUp, keyDown, keyJump,
        input  topLeftX, topLeftY, motionState, score, fruitPulse, lives, gameOver
    );
    modport slave (
        input  startOfFrame, hitPulse, keyLeft, keyRight, keyUp, keyDown, keyJump,
        output topLeftX, topLeftY, motionState, score, fruitPulse, lives, gameOver
    );
`else
    modport master (
        output startOfFrame, hitPulse, keyLeft, keyRight, keyUp, keyDown, keyJump,
        input  topLeftX, topLeftY, motionState, score, fruitPulse
    );
    modport slave (
        input  startOfFrame, hitPulse, keyLeft, keyRight, keyUp, keyDown, keyJump,
        output topLeftX, topLeftY, motionState, score, fruitPulse
    );
`endif
endinterface

// File: rtl/monkey_motion_ctrl.sv
// Monkey movement controller: latches per-frame collision pulses, runs the
// FALL/WALK/CLIMB/JUMP state machine once per frame in x64 fixed point, and
// counts fruits. Build option: MONKEY_LIVES_EN adds a 3-life counter and a
// game-over freeze.
module monkey_motion_ctrl #(
    parameter int INIT_X      = 64,
    parameter int INIT_Y      = 32,
    parameter int OBJ_W       = 32,
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int FIXED_SHIFT = 6,
    parameter int X_SPEED     = 128,
    parameter int CLIMB_SPEED = 96,
    parameter int JUMP_SPEED  = 320,
    parameter int GRAVITY     = 16,
    parameter int MAX_Y_SPEED = 384
) (
    input  logic                 clk,
    input  logic                 reset,
    monkey_motion_ctrl_if.slave  bus
);

    localparam int POS_W = 18;

    typedef enum logic [1:0] {
        FALL  = 2'd0,
        WALK  = 2'd1,
        CLIMB = 2'd2,
        JUMP  = 2'd3
    } motion_t;

    localparam logic signed [POS_W-1:0] ZERO_S   = '0;
    localparam logic signed [POS_W-1:0] INIT_XS  = POS_W'(INIT_X << FIXED_SHIFT);
    localparam logic signed [POS_W-1:0] INIT_YS  = POS_W'(INIT_Y << FIXED_SHIFT);
    localparam logic signed [POS_W-1:0] X_MAX_S  = POS_W'((SCREEN_W - OBJ_W) << FIXED_SHIFT);
    // Pixel Y above SCREEN_H means fixed-point Y at or past (SCREEN_H+1) << shift.
    localparam logic signed [POS_W-1:0] Y_EXIT_S = POS_W'((SCREEN_H + 1) << FIXED_SHIFT);
    localparam logic signed [POS_W-1:0] WALK_S   = POS_W'(X_SPEED);
    localparam logic signed [POS_W-1:0] CLIMB_S  = POS_W'(CLIMB_SPEED);
    localparam logic signed [POS_W-1:0] JUMP_S   = POS_W'(JUMP_SPEED);
    localparam logic signed [POS_W-1:0] GRAV_S   = POS_W'(GRAVITY);
    localparam logic signed [POS_W-1:0] MAX_YS   = POS_W'(MAX_Y_SPEED);

    motion_t                  state;
    motion_t                  stateNext;
    logic signed [POS_W-1:0]  posX, posY, xSpd, ySpd;
    logic signed [POS_W-1:0]  posXNext, posYNext, xSpdNext, ySpdNext;
    logic signed [POS_W-1:0]  ySum, yGrav, xSum, keyXSpd, moveXSpd;
    logic                     respawn;
    logic                     floorF, ropeF;
    logic [7:0]               score;
    logic                     fruitPulse;
    logic                     frozen;

`ifdef MONKEY_LIVES_EN
    logic [1:0] lives;
    logic       gameOver;

    assign frozen       = gameOver;
    assign bus.lives    = lives;
    assign bus.gameOver = gameOver;
`else
    assign frozen = 1'b0;
`endif

    // Next motion state, speeds and position for the coming frame update.
    always_comb begin
        stateNext = state;
        moveXSpd  = xSpd;
        ySpdNext  = ySpd;
        xSpdNext  = xSpd;
        posXNext  = posX;
        posYNext  = posY;
        respawn   = 1'b0;
        ySum      = ySpd + GRAV_S;
        yGrav     = (ySum > MAX_YS) ? MAX_YS : ySum;
        xSum      = ZERO_S;

        case ({bus.keyLeft, bus.keyRight})
            2'b10:   keyXSpd = -WALK_S;
            2'b01:   keyXSpd = WALK_S;
            default: keyXSpd = ZERO_S;
        endcase

        case (state)
            FALL: begin
                ySpdNext = yGrav;
                if (floorF) begin
                    // Landing keeps the pre-update Y so the sprite does not sink.
                    stateNext = WALK;
                    ySpdNext  = ZERO_S;
                end
            end
            WALK: begin
                moveXSpd = keyXSpd;
                ySpdNext = ZERO_S;
                if (!floorF) begin
                    stateNext = FALL;
                end else if (bus.keyUp && ropeF) begin
                    stateNext = CLIMB;
                end else if (bus.keyJump) begin
                    stateNext = JUMP;
                    ySpdNext  = -JUMP_S;
                end
            end
            CLIMB: begin
                moveXSpd = ZERO_S;
                if (bus.keyUp)
                    ySpdNext = -CLIMB_S;
                else if (bus.keyDown)
                    ySpdNext = CLIMB_S;
                else
                    ySpdNext = ZERO_S;
                if (!ropeF) begin
                    stateNext = FALL;
                end else if (floorF && bus.keyDown) begin
                    stateNext = WALK;
                    ySpdNext  = ZERO_S;
                end
            end
            default: begin  // JUMP: floor contact is ignored while rising
                ySpdNext = yGrav;
                if (yGrav >= ZERO_S)
                    stateNext = FALL;
            end
        endcase

        // Horizontal clamp to the visible area; hitting an edge kills X speed.
        xSpdNext = moveXSpd;
        xSum     = posX + moveXSpd;
        if (xSum < ZERO_S) begin
            posXNext = ZERO_S;
            xSpdNext = ZERO_S;
        end else if (xSum > X_MAX_S) begin
            posXNext = X_MAX_S;
            xSpdNext = ZERO_S;
        end else begin
            posXNext = xSum;
        end

        posYNext = posY + ySpdNext;

        // Dropping below the screen restarts the monkey at its spawn point.
        if (posYNext >= Y_EXIT_S) begin
            respawn   = 1'b1;
            stateNext = FALL;
            posXNext  = INIT_XS;
            posYNext  = INIT_YS;
            xSpdNext  = ZERO_S;
            ySpdNext  = ZERO_S;
        end
    end

    // Motion registers advance only on the start-of-frame strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FALL;
            posX  <= INIT_XS;
            posY  <= INIT_YS;
            xSpd  <= ZERO_S;
            ySpd  <= ZERO_S;
        end else if (bus.startOfFrame && !frozen) begin
            state <= stateNext;
            posX  <= posXNext;
            posY  <= posYNext;
            xSpd  <= xSpdNext;
            ySpd  <= ySpdNext;
        end
    end

    // Hit flags: a pulse arriving with startOfFrame belongs to the next frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            floorF <= 1'b0;
            ropeF  <= 1'b0;
        end else if (!frozen) begin
            if (bus.startOfFrame) begin
                floorF <= bus.hitPulse[0];
                ropeF  <= bus.hitPulse[1];
            end else begin
                floorF <= floorF | bus.hitPulse[0];
                ropeF  <= ropeF | bus.hitPulse[1];
            end
        end
    end

    // Fruit score, saturating at 255, with a one-cycle echo pulse per fruit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            score      <= 8'd0;
            fruitPulse <= 1'b0;
        end else begin
            fruitPulse <= bus.hitPulse[2] && !frozen;
            if (bus.hitPulse[2] && !frozen && (score != 8'd255))
                score <= score + 8'd1;
        end
    end

`ifdef MONKEY_LIVES_EN
    // Each respawn costs a life; losing the last one freezes the game.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lives    <= 2'd3;
            gameOver <= 1'b0;
        end else if (bus.startOfFrame && !frozen && respawn) begin
            lives <= lives - 2'd1;
            if (lives == 2'd1)
                gameOver <= 1'b1;
        end
    end
`endif

    assign bus.topLeftX    = posX[FIXED_SHIFT+10:FIXED_SHIFT];
    assign bus.topLeftY    = posY[FIXED_SHIFT+10:FIXED_SHIFT];
    assign bus.motionState = state;
    assign bus.score       = score;
    assign bus.fruitPulse  = fruitPulse;

endmodule

// File: tb/tb_monkey_motion_ctrl.sv
// Directed bench for monkey_motion_ctrl: falling, landing, walking with edge
// clamp, climbing, jumping, fruit scoring with saturation, and Y-exit respawn
// (plus lives/game-over when MONKEY_LIVES_EN is defined).
module tb_monkey_motion_ctrl;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] exp_q[$];
    int   expScore = 0;
    bit   found;
    int   lastY;

    monkey_motion_ctrl_if mif();

    monkey_motion_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (mif)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Scoreboard comparison
    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One frame: hit pulses in the cycle before startOfFrame, then the strobe.
    task automatic frame(input logic [2:0] hits);
        mif.hitPulse = hits;
        tick();
        mif.hitPulse     = 3'b000;
        mif.startOfFrame = 1'b1;
        tick();
        mif.startOfFrame = 1'b0;
    endtask

    task automatic fruit_hit(input logic withSof);
        mif.hitPulse     = 3'b100;
        mif.startOfFrame = withSof;
        tick();
        mif.hitPulse     = 3'b000;
        mif.startOfFrame = 1'b0;
        expScore = (expScore == 255) ? 255 : expScore + 1;
        exp_q.push_back(8'(expScore));
        check("fruit_pulse_hi", mif.fruitPulse, 1);
        check("fruit_score", mif.score, exp_q.pop_front());
        tick();
        check("fruit_pulse_lo", mif.fruitPulse, 0);
    endtask

    // Fall frames with no hits until the monkey reappears at the spawn row.
    task automatic wait_exit(output bit ok, output int prevY);
        int y;
        ok    = 1'b0;
        prevY = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            y = int'(mif.topLeftY);
            frame(3'b000);
            if (y > 400 && mif.topLeftY == 11'sd32) begin
                ok    = 1'b1;
                prevY = y;
            end
        end
    endtask

    initial begin
        mif.startOfFrame = 1'b0;
        mif.hitPulse     = 3'b000;
        mif.keyLeft      = 1'b0;
        mif.keyRight     = 1'b0;
        mif.keyUp        = 1'b0;
        mif.keyDown      = 1'b0;
        mif.keyJump      = 1'b0;
        reset            = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        check("rst_state", mif.motionState, 0);
        check("rst_x", mif.topLeftX, 64);
        check("rst_y", mif.topLeftY, 32);
        check("rst_score", mif.score, 0);
        check("rst_fruit", mif.fruitPulse, 0);
`ifdef MONKEY_LIVES_EN
        check("rst_lives", mif.lives, 3);
        check("rst_gameover", mif.gameOver, 0);
`endif

        // A floor flag latched before a mid-frame reset must be lost
        mif.hitPulse = 3'b001;
        tick();
        mif.hitPulse = 3'b000;
        reset = 1'b1;
        tick();
        reset = 1'b0;

        // Three free-fall frames: Y 2064, 2096, 2144 fixed point
        frame(3'b000);
        check("fall1_state", mif.motionState, 0);
        check("fall1_y", mif.topLeftY, 32);
        frame(3'b000);
        check("fall2_y", mif.topLeftY, 32);
        frame(3'b000);
        check("fall3_y", mif.topLeftY, 33);
        check("fall3_x", mif.topLeftX, 64);

        // Landing keeps Y, then walk right by 2 pixels
        frame(3'b001);
        check("land_state", mif.motionState, 1);
        check("land_y", mif.topLeftY, 33);
        mif.keyRight = 1'b1;
        frame(3'b001);
        check("walk_r_x", mif.topLeftX, 66);
        check("walk_r_y", mif.topLeftY, 33);
        mif.keyRight = 1'b0;

        // Walk left into the X=0 edge and stay clamped there
        mif.keyLeft = 1'b1;
        for (int i = 0; i < 33; i++) frame(3'b001);
        check("walk_l_x0", mif.topLeftX, 0);
        frame(3'b001);
        check("clamp1_x", mif.topLeftX, 0);
        frame(3'b001);
        check("clamp2_x", mif.topLeftX, 0);
        mif.keyRight = 1'b1;
        frame(3'b001);
        check("both_at0_x", mif.topLeftX, 0);
        mif.keyLeft = 1'b0;
        frame(3'b001);
        check("right_off_edge_x", mif.topLeftX, 2);
        mif.keyLeft = 1'b1;
        frame(3'b001);
        check("both_x", mif.topLeftX, 2);
        mif.keyLeft  = 1'b0;
        mif.keyRight = 1'b0;

        // Climb: enter on rope+floor with keyUp, then rise 1.5 px per frame
        mif.keyUp = 1'b1;
        frame(3'b011);
        check("climb_enter_state", mif.motionState, 2);
        check("climb_enter_y", mif.topLeftY, 33);
        frame(3'b010);
        check("climb1_y", mif.topLeftY, 32);
        frame(3'b010);
        check("climb2_y", mif.topLeftY, 30);
        check("climb2_x", mif.topLeftX, 2);
        mif.keyUp = 1'b0;
        frame(3'b000);
        check("rope_lost_state", mif.motionState, 0);
        check("rope_lost_y", mif.topLeftY, 30);

        // Land, jump (-5 px), then rise under gravity; floor ignored in JUMP
        frame(3'b001);
        check("land2_state", mif.motionState, 1);
        mif.keyJump = 1'b1;
        frame(3'b001);
        check("jump_state", mif.motionState, 3);
        check("jump_y", mif.topLeftY, 25);
        mif.keyJump = 1'b0;
        frame(3'b001);
        check("jump2_state", mif.motionState, 3);
        check("jump2_y", mif.topLeftY, 20);
        check("jump2_x", mif.topLeftX, 2);

        // Fruit: one coincident with startOfFrame, then up to saturation
        fruit_hit(1'b1);
        for (int i = 0; i < 299; i++) fruit_hit(1'b0);
        check("score_sat", mif.score, 255);

        // Y exit respawns at the spawn point in FALL
        wait_exit(found, lastY);
        check("exit1_seen", found, 1);
        check("exit1_last_y_on_screen", (lastY <= 480), 1);
        check("exit1_x", mif.topLeftX, 64);
        check("exit1_state", mif.motionState, 0);
`ifdef MONKEY_LIVES_EN
        check("exit1_lives", mif.lives, 2);
        check("exit1_gameover", mif.gameOver, 0);
        wait_exit(found, lastY);
        check("exit2_seen", found, 1);
        check("exit2_lives", mif.lives, 1);
        check("exit2_gameover", mif.gameOver, 0);
        wait_exit(found, lastY);
        check("exit3_seen", found, 1);
        check("exit3_lives", mif.lives, 0);
        check("exit3_gameover", mif.gameOver, 1);
        for (int i = 0; i < 3; i++) frame(3'b001);
        check("frozen_x", mif.topLeftX, 64);
        check("frozen_y", mif.topLeftY, 32);
        check("frozen_state", mif.motionState, 0);
        mif.hitPulse = 3'b100;
        tick();
        mif.hitPulse = 3'b000;
        check("frozen_fruit", mif.fruitPulse, 0);
        check("frozen_score", mif.score, 255);
`else
        frame(3'b000);
        check("after_exit_y", mif.topLeftY, 32);
        check("after_exit_state", mif.motionState, 0);
        wait_exit(found, lastY);
        check("exit2_seen", found, 1);
        check("exit2_x", mif.topLeftX, 64);
`endif

        // Final report
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
